// File: rtl/overlay_pkg.sv
//==============================================================================
// Module  : overlay_pkg
// Brief   : Shared types and constants for the overlay fetch controller:
//           region descriptor, config field codes, config FSM states,
//           default widths and the transparency colour key.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package overlay_pkg;

   localparam int c_AW_DEF = 13;
   localparam int c_CW_DEF = 12;

   // Fetched colour treated as "see-through" when transparency is enabled
   localparam logic [c_CW_DEF-1:0] c_COLOR_KEY = 12'h000;

   // One programmable rectangle; image stored column-major from base
   typedef struct packed {
      logic [9:0]          x0;
      logic [9:0]          y0;
      logic [7:0]          w;
      logic [7:0]          h;
      logic [c_AW_DEF-1:0] base;
   } region_t;

   typedef enum logic [2:0] {
      FLD_X0   = 3'd0,
      FLD_Y0   = 3'd1,
      FLD_W    = 3'd2,
      FLD_H    = 3'd3,
      FLD_BASE = 3'd4
   } cfg_field_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } cfg_state_e;

endpackage

`default_nettype wire

// File: rtl/overlay_region_match.sv
//==============================================================================
// Module  : overlay_region_match
// Brief   : Coverage test of one pixel against one rectangle, plus the
//           column-major offset (y-y0) + (x-x0)*h inside that rectangle.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module overlay_region_match
   import overlay_pkg::*;
(
   input  logic                i_video_on,
   input  logic [9:0]          i_x,
   input  logic [9:0]          i_y,
   input  region_t             i_region,
   output logic                o_hit,
   output logic [c_AW_DEF-1:0] o_offset
);

   logic [10:0]         w_x_end;
   logic [10:0]         w_y_end;
   logic                w_in_x;
   logic                w_in_y;
   logic [9:0]          w_dx;
   logic [9:0]          w_dy;

   // Ends are formed one bit wider so a rectangle near 1023 cannot wrap
   assign w_x_end = {1'b0, i_region.x0} + {3'b000, i_region.w};
   assign w_y_end = {1'b0, i_region.y0} + {3'b000, i_region.h};

   // A zero width or height makes the end equal the start, so nothing hits
   assign w_in_x = (i_x >= i_region.x0) && ({1'b0, i_x} < w_x_end);
   assign w_in_y = (i_y >= i_region.y0) && ({1'b0, i_y} < w_y_end);
   assign o_hit  = i_video_on && w_in_x && w_in_y;

   // Offsets are only meaningful on a hit; arithmetic is modulo 2^AW
   assign w_dx     = i_x - i_region.x0;
   assign w_dy     = i_y - i_region.y0;
   assign o_offset = c_AW_DEF'(w_dy) + (c_AW_DEF'(w_dx) * c_AW_DEF'(i_region.h));

endmodule

`default_nettype wire

// File: rtl/overlay_fetch_ctrl.sv
//==============================================================================
// Module  : overlay_fetch_ctrl
// Brief   : Overlay image memory scheduler. Matches each pixel against NREG
//           rectangles (lowest index wins), pipelines the fetch address,
//           shares the single memory port with an update writer, and commits
//           a shadow region table to the active table at frame start.
// Config  : OVL_TRANSPARENT_EN - fetched colour c_COLOR_KEY shows bg_rgb.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module overlay_fetch_ctrl
   import overlay_pkg::*;
#(
   parameter int NREG = 4,
   parameter int AW   = c_AW_DEF,
   parameter int CW   = c_CW_DEF
)(
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_tick,
   input  logic          video_on,
   input  logic [9:0]    pixel_x,
   input  logic [9:0]    pixel_y,
   input  logic          cfg_wr,
   input  logic [1:0]    cfg_idx,
   input  logic [2:0]    cfg_field,
   input  logic [12:0]   cfg_data,
   output logic          cfg_ack,
   input  logic          upd_req,
   input  logic [AW-1:0] upd_addr,
   input  logic [CW-1:0] upd_data,
   output logic          upd_gnt,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [CW-1:0] mem_wdata,
   input  logic [CW-1:0] mem_rdata,
   input  logic [CW-1:0] bg_rgb,
   output logic          hit,
   output logic [CW-1:0] rgb_out
);

   region_t             r_shadow [NREG];
   region_t             r_active [NREG];
   cfg_state_e          r_state;
   cfg_state_e          w_state_nxt;
   logic                w_frame_start;
   logic                w_commit;
   logic                r_cfg_ack;

   logic [NREG-1:0]     w_hit;
   logic [c_AW_DEF-1:0] w_offset [NREG];
   logic                w_any_hit;
   logic [c_AW_DEF-1:0] w_sel_base;
   logic [c_AW_DEF-1:0] w_sel_offset;

   logic                r_s1_vld;
   logic [c_AW_DEF-1:0] r_s1_base;
   logic [c_AW_DEF-1:0] r_s1_offset;
   logic                r_s2_vld;
   logic [AW-1:0]       r_s2_addr;
   logic                r_hit;
   logic [CW-1:0]       r_rgb;

   logic                w_upd_gnt;
   logic [AW-1:0]       w_mem_addr;
   logic                w_mem_we;
   logic [CW-1:0]       w_mem_wdata;

   assign w_frame_start = pix_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

   //---------------------------------------------------------------------------
   // Configuration: shadow table, active table, commit FSM
   //---------------------------------------------------------------------------

   // Register writes always land in the shadow table
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) r_shadow[i] <= '0;
      end else if (cfg_wr) begin
         for (int i = 0; i < NREG; i++) begin
            if (cfg_idx == 2'(i)) begin
               case (cfg_field_e'(cfg_field))
                  FLD_X0:   r_shadow[i].x0   <= cfg_data[9:0];
                  FLD_Y0:   r_shadow[i].y0   <= cfg_data[9:0];
                  FLD_W:    r_shadow[i].w    <= cfg_data[7:0];
                  FLD_H:    r_shadow[i].h    <= cfg_data[7:0];
                  FLD_BASE: r_shadow[i].base <= cfg_data[c_AW_DEF-1:0];
                  default:  ;
               endcase
            end
         end
      end
   end

   // Active table copies the pre-write shadow at commit, so no mid-frame tearing
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) r_active[i] <= '0;
      end else if (w_commit) begin
         for (int i = 0; i < NREG; i++) r_active[i] <= r_shadow[i];
      end
   end

   // Acknowledge every write, including ignored field codes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_cfg_ack <= 1'b0;
      else       r_cfg_ack <= cfg_wr;
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // FSM next state: a write arriving on the commit cycle keeps us pending
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (cfg_wr) w_state_nxt = ST_PEND;
         ST_PEND: if (w_frame_start && !cfg_wr) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: commit only when something is pending at frame start
   always_comb begin
      w_commit = (r_state == ST_PEND) && w_frame_start;
   end

   assign cfg_ack = r_cfg_ack;

   //---------------------------------------------------------------------------
   // Display pipeline: match -> address -> fetch
   //---------------------------------------------------------------------------

   generate
      for (genvar r = 0; r < NREG; r++) begin : g_region
         overlay_region_match u_match (
            .i_video_on (video_on),
            .i_x        (pixel_x),
            .i_y        (pixel_y),
            .i_region   (r_active[r]),
            .o_hit      (w_hit[r]),
            .o_offset   (w_offset[r])
         );
      end
   endgenerate

   // Priority select: scan high to low so the lowest index is assigned last
   always_comb begin
      w_any_hit    = 1'b0;
      w_sel_base   = '0;
      w_sel_offset = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_any_hit    = 1'b1;
            w_sel_base   = r_active[i].base;
            w_sel_offset = w_offset[i];
         end
      end
   end

   // S1: capture the winning region's base and in-region offset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_vld    <= 1'b0;
         r_s1_base   <= '0;
         r_s1_offset <= '0;
      end else if (pix_tick) begin
         r_s1_vld    <= w_any_hit;
         r_s1_base   <= w_sel_base;
         r_s1_offset <= w_sel_offset;
      end
   end

   // S2: form the memory address; valid bit claims the memory port
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s2_vld  <= 1'b0;
         r_s2_addr <= '0;
      end else if (pix_tick) begin
         r_s2_vld  <= r_s1_vld;
         r_s2_addr <= AW'(r_s1_base) + AW'(r_s1_offset);
      end
   end

   // S3: capture the read data (already valid one clk after the address)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hit <= 1'b0;
         r_rgb <= '0;
      end else if (pix_tick) begin
`ifdef OVL_TRANSPARENT_EN
         if (r_s2_vld && (mem_rdata != CW'(c_COLOR_KEY))) begin
            r_hit <= 1'b1;
            r_rgb <= mem_rdata;
         end else begin
            r_hit <= 1'b0;
            r_rgb <= bg_rgb;
         end
`else
         r_hit <= r_s2_vld;
         r_rgb <= r_s2_vld ? mem_rdata : '0;
`endif
      end
   end

`ifndef OVL_TRANSPARENT_EN
   // Background colour only matters when transparency is built in
   logic w_unused_bg;
   assign w_unused_bg = ^bg_rgb;
`endif

   assign hit     = r_hit;
   assign rgb_out = r_rgb;

   //---------------------------------------------------------------------------
   // Memory port arbitration
   //---------------------------------------------------------------------------

   // Display wins while a fetch is in S2; otherwise the writer passes straight through
   always_comb begin
      w_upd_gnt   = 1'b0;
      w_mem_addr  = r_s2_addr;
      w_mem_we    = 1'b0;
      w_mem_wdata = '0;
      if (!r_s2_vld) begin
         w_upd_gnt   = upd_req && !reset;
         w_mem_addr  = upd_addr;
         w_mem_we    = w_upd_gnt;
         w_mem_wdata = upd_data;
      end
   end

   assign upd_gnt   = w_upd_gnt;
   assign mem_addr  = w_mem_addr;
   assign mem_we    = w_mem_we;
   assign mem_wdata = w_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_overlay_fetch_ctrl.sv
//==============================================================================
// Module  : tb_overlay_fetch_ctrl
// Brief   : Directed self-checking bench for overlay_fetch_ctrl with a
//           synchronous memory model (unwritten word a holds 12'(a)+12'h100).
// Config  : OVL_TRANSPARENT_EN changes miss/colour-key expectations.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_overlay_fetch_ctrl;
   import overlay_pkg::*;

`ifdef OVL_TRANSPARENT_EN
   localparam logic [11:0] c_MISS_RGB = 12'hABC;
   localparam logic        c_KEY_HIT  = 1'b0;
   localparam logic [11:0] c_KEY_RGB  = 12'hABC;
`else
   localparam logic [11:0] c_MISS_RGB = 12'h000;
   localparam logic        c_KEY_HIT  = 1'b1;
   localparam logic [11:0] c_KEY_RGB  = 12'h000;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_tick = 1'b0;
   logic        video_on = 1'b0;
   logic [9:0]  pixel_x = '0;
   logic [9:0]  pixel_y = '0;
   logic        cfg_wr = 1'b0;
   logic [1:0]  cfg_idx = '0;
   logic [2:0]  cfg_field = '0;
   logic [12:0] cfg_data = '0;
   logic        cfg_ack;
   logic        upd_req = 1'b0;
   logic [12:0] upd_addr = '0;
   logic [11:0] upd_data = '0;
   logic        upd_gnt;
   logic [12:0] mem_addr;
   logic        mem_we;
   logic [11:0] mem_wdata;
   logic [11:0] mem_rdata;
   logic [11:0] bg_rgb = 12'hABC;
   logic        hit;
   logic [11:0] rgb_out;

   int n_cmp = 0;
   int n_bad = 0;

   overlay_fetch_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .pix_tick  (pix_tick),
      .video_on  (video_on),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .cfg_wr    (cfg_wr),
      .cfg_idx   (cfg_idx),
      .cfg_field (cfg_field),
      .cfg_data  (cfg_data),
      .cfg_ack   (cfg_ack),
      .upd_req   (upd_req),
      .upd_addr  (upd_addr),
      .upd_data  (upd_data),
      .upd_gnt   (upd_gnt),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .bg_rgb    (bg_rgb),
      .hit       (hit),
      .rgb_out   (rgb_out)
   );

   always #5 clk = ~clk;

   // Synchronous memory model with a bench-side poke port
   bit [11:0]   mem    [8192];
   bit          mem_wr [8192];
   logic        tb_poke = 1'b0;
   logic [12:0] tb_poke_addr = '0;
   logic [11:0] tb_poke_data = '0;

   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr]    <= mem_wdata;
         mem_wr[mem_addr] <= 1'b1;
      end else if (tb_poke) begin
         mem[tb_poke_addr]    <= tb_poke_data;
         mem_wr[tb_poke_addr] <= 1'b1;
      end
      mem_rdata <= mem_wr[mem_addr] ? mem[mem_addr] : 12'(mem_addr) + 12'h100;
   end

   // Counts cycles where the writer got the port
   int busy_cnt = 0;
   always @(negedge clk) begin
      if (upd_gnt || mem_we) busy_cnt <= busy_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One pixel tick, then one idle clock; returns on a falling edge
   task automatic tick(input logic [9:0] x, input logic [9:0] y, input logic v);
      pixel_x  = x;
      pixel_y  = y;
      video_on = v;
      pix_tick = 1'b1;
      @(negedge clk);
      pix_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic blank();
      tick(10'd1000, 10'd1000, 1'b0);
   endtask

   task automatic cfg_write(input int idx, input cfg_field_e f, input int data);
      cfg_idx   = 2'(idx);
      cfg_field = f;
      cfg_data  = 13'(data);
      cfg_wr    = 1'b1;
      @(negedge clk);
      cfg_wr = 1'b0;
      chk("cfg_ack_pulse", cfg_ack, 1);
      @(negedge clk);
      chk("cfg_ack_drop", cfg_ack, 0);
   endtask

   task automatic probe(input string tag, input int x, input int y, input logic fetch,
                        input int exp_addr, input logic exp_hit, input logic [11:0] exp_rgb);
      tick(10'(x), 10'(y), 1'b1);
      blank();
      if (fetch) chk({tag, ".addr"}, mem_addr, exp_addr);
      chk({tag, ".we"}, mem_we, 0);
      blank();
      chk({tag, ".hit"}, hit, exp_hit);
      chk({tag, ".rgb"}, rgb_out, exp_rgb);
   endtask

   initial begin
      int sweep_bad;
      int c0;

      // ---- reset state
      reset = 1'b0;
      #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst.hit", hit, 0);
      chk("rst.rgb", rgb_out, 0);
      chk("rst.we", mem_we, 0);
      chk("rst.gnt", upd_gnt, 0);
      chk("rst.ack", cfg_ack, 0);
      reset = 1'b0;
      @(negedge clk);

      // ---- empty table: a frame of pixels never hits
      sweep_bad = 0;
      for (int y = 0; y < 480; y += 16) begin
         for (int x = 0; x < 640; x += 16) begin
            tick(10'(x), 10'(y), 1'b1);
            if (hit !== 1'b0 || rgb_out !== 12'h000 || mem_we !== 1'b0) sweep_bad++;
         end
      end
      chk("sweep_empty", sweep_bad, 0);

      // ---- region0 = {15,72,60,38,0}, committed at frame start
      cfg_write(0, FLD_X0, 15);
      cfg_write(0, FLD_Y0, 72);
      cfg_write(0, FLD_W, 60);
      cfg_write(0, FLD_H, 38);
      cfg_write(0, FLD_BASE, 0);
      cfg_write(0, cfg_field_e'(3'd6), 123);   // ignored field code
      tick(10'd0, 10'd0, 1'b1);
      probe("r0_16_73", 16, 73, 1, 39, 1, 12'h127);
      probe("r0_left", 14, 72, 0, 0, 0, c_MISS_RGB);
      probe("r0_right", 75, 72, 0, 0, 0, c_MISS_RGB);
      probe("r0_corner", 74, 109, 1, 2279, 1, 12'h9E7);
      probe("r0_below", 74, 110, 0, 0, 0, c_MISS_RGB);

      // ---- region1 overlaps region0; region2 exercises address wrap
      cfg_write(1, FLD_X0, 18);
      cfg_write(1, FLD_Y0, 78);
      cfg_write(1, FLD_W, 100);
      cfg_write(1, FLD_H, 40);
      cfg_write(1, FLD_BASE, 500);
      cfg_write(2, FLD_X0, 200);
      cfg_write(2, FLD_Y0, 200);
      cfg_write(2, FLD_W, 255);
      cfg_write(2, FLD_H, 255);
      cfg_write(2, FLD_BASE, 8000);
      probe("r1_uncommitted", 100, 80, 0, 0, 0, c_MISS_RGB);
      tick(10'd0, 10'd0, 1'b1);
      probe("overlap_r0", 20, 80, 1, 198, 1, 12'h1C6);
      probe("r1_only", 100, 80, 1, 3782, 1, 12'hFC6);
      probe("r2_wrap", 454, 454, 1, 7488, 1, 12'hE40);

      // ---- writer held off while the display owns the port
      tick(10'd16, 10'd73, 1'b1);
      tick(10'd17, 10'd73, 1'b1);
      upd_req  = 1'b1;
      upd_addr = 13'd5000;
      upd_data = 12'h3C3;
      c0 = busy_cnt;
      for (int i = 0; i < 5; i++) tick(10'(18 + i), 10'd73, 1'b1);
      blank();
      chk("arb_held_off", busy_cnt - c0, 0);
      blank();
      chk("arb_gnt", upd_gnt, 1);
      chk("arb_we", mem_we, 1);
      chk("arb_addr", mem_addr, 5000);
      chk("arb_wdata", mem_wdata, 12'h3C3);
      @(posedge clk);
      #1 upd_req = 1'b0;
      chk("arb_written", mem[5000], 12'h3C3);
      @(negedge clk);
      chk("arb_gnt_drop", upd_gnt, 0);

      // ---- mid-frame reconfiguration waits for frame start
      cfg_write(1, FLD_X0, 470);
      probe("r1_not_moved", 100, 80, 1, 3782, 1, 12'hFC6);
      // commit and a further write on the same cycle
      cfg_idx   = 2'd1;
      cfg_field = FLD_Y0;
      cfg_data  = 13'd300;
      cfg_wr    = 1'b1;
      pixel_x   = 10'd0;
      pixel_y   = 10'd0;
      video_on  = 1'b1;
      pix_tick  = 1'b1;
      @(negedge clk);
      cfg_wr   = 1'b0;
      pix_tick = 1'b0;
      @(negedge clk);
      probe("r1_moved_away", 100, 80, 0, 0, 0, c_MISS_RGB);
      probe("r1_moved_to", 480, 80, 1, 902, 1, 12'h486);
      tick(10'd0, 10'd0, 1'b1);
      probe("r1_y_old", 480, 80, 0, 0, 0, c_MISS_RGB);
      probe("r1_y_new", 480, 300, 1, 900, 1, 12'h484);

      // ---- colour key word at a hit
      tb_poke_addr = 13'd39;
      tb_poke_data = 12'h000;
      tb_poke      = 1'b1;
      @(negedge clk);
      tb_poke = 1'b0;
      probe("color_key", 16, 73, 1, 39, c_KEY_HIT, c_KEY_RGB);

      // ---- reset in the middle of a frame with a pending update
      tick(10'd17, 10'd73, 1'b1);
      tick(10'd18, 10'd73, 1'b1);
      upd_req  = 1'b1;
      upd_addr = 13'd6000;
      upd_data = 12'h5A5;
      tick(10'd19, 10'd73, 1'b1);
      chk("pre_rst.hit", hit, 1);
      chk("pre_rst.rgb", rgb_out, 12'h14D);
      chk("pre_rst.gnt", upd_gnt, 0);
      reset = 1'b1;
      #1;
      chk("mid_rst.hit", hit, 0);
      chk("mid_rst.rgb", rgb_out, 0);
      chk("mid_rst.gnt", upd_gnt, 0);
      chk("mid_rst.we", mem_we, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst.regrant", upd_gnt, 1);
      @(negedge clk);
      upd_req = 1'b0;
      probe("post_rst.cleared", 16, 73, 0, 0, 0, c_MISS_RGB);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
